// File: rtl/decrypt_pkg.sv
// Shared definitions for the encrypt/decrypt pair: cipher modes, the
// decrypt FSM states and the default key material.
package decrypt_pkg;

    // Cipher mode, encoded as carried on the select bus.
    typedef enum logic [1:0] {
        BYPASS = 2'b00,
        XOR    = 2'b01,
        ROTATE = 2'b10,
        CHAIN  = 2'b11
    } mode_e;

    // Decrypt control FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DECODE = 2'b01,
        OUTPUT = 2'b10
    } state_e;

    // Defaults shared with encrypt so both ends agree out of the box.
    localparam logic [7:0] KEY_DEFAULT = 8'hA5;
    localparam logic [7:0] IV_DEFAULT  = 8'h3C;
    localparam int         ROT_DEFAULT = 3;

endpackage

// File: rtl/decrypt_cipher.sv
// Purely combinational inverse cipher: turns one ciphertext byte into
// plaintext for the given mode. The chain value is supplied by the caller.
module decrypt_cipher
    import decrypt_pkg::*;
#(
    parameter logic [7:0] KEY = KEY_DEFAULT,
    parameter int         ROT = ROT_DEFAULT
) (
    input  logic [7:0] c,
    input  mode_e      mode,
    input  logic [7:0] prev,
    output logic [7:0] p
);

    // Rotating right by ROT is picking 8 bits starting at ROT out of the
    // byte concatenated with itself.
    logic [15:0] c_twice;
    assign c_twice = {c, c};

    // Select the inverse transform for the requested mode.
    always_comb begin
        p = c;
        case (mode)
            BYPASS:  p = c;
            XOR:     p = c ^ KEY;
            ROTATE:  p = c_twice[ROT +: 8];
            CHAIN:   p = c ^ prev ^ KEY;
            default: p = c;
        endcase
    end

endmodule

// File: rtl/decrypt.sv
// Byte-serial decrypter: accepts one ciphertext byte, decodes it, and holds
// the plaintext until the consumer takes it. Owns the FSM, chain register
// and delivered-byte counter; the transform itself lives in decrypt_cipher.
//
// Handshakes: a byte moves on a rising edge where valid and ready are both 1.
// Input side: in_ready is 1 only in IDLE (and never during reset), so at most
// one byte is in flight. Output side: once out_valid rises, de_data stays
// fixed and out_valid stays 1 until an edge with out_ready = 1.
module decrypt
    import decrypt_pkg::*;
#(
    parameter logic [7:0] KEY = KEY_DEFAULT,
    parameter logic [7:0] IV  = IV_DEFAULT,
    parameter int         ROT = ROT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] select,
    input  logic [7:0] en_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       chain_clr,
    output logic [7:0] de_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] byte_cnt,
    output logic [1:0] state_dbg
);

    state_e     state_q;
    state_e     state_d;
    logic       accept;
    logic       deliver;
    logic [7:0] c_q;       // latched ciphertext
    mode_e      mode_q;    // latched mode
    logic [7:0] chain_q;   // chain value this byte decodes with
    logic [7:0] prev_q;    // running chain register
    logic [7:0] plain;

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign state_dbg = state_q;

    // Next-state logic: one byte walks IDLE -> DECODE -> OUTPUT -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = DECODE;
            DECODE:  state_d = OUTPUT;
            OUTPUT:  if (deliver) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Capture the byte, its mode and its chain value so later input
    // changes (including chain_clr) cannot disturb the byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q     <= 8'h00;
            mode_q  <= BYPASS;
            chain_q <= 8'h00;
        end else if (accept) begin
            c_q     <= en_data;
            mode_q  <= mode_e'(select);
            chain_q <= chain_clr ? IV : prev_q;
        end
    end

    // Chain register: a chained byte becomes the next chain value, which
    // takes precedence over a coincident chain_clr (that clear was already
    // applied to the byte itself via chain_q).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         prev_q <= IV;
        else if (accept && (mode_e'(select) == CHAIN))   prev_q <= en_data;
        else if (chain_clr)                              prev_q <= IV;
    end

    decrypt_cipher #(
        .KEY (KEY),
        .ROT (ROT)
    ) u_cipher (
        .c    (c_q),
        .mode (mode_q),
        .prev (chain_q),
        .p    (plain)
    );

    // Output register: de_data loads in DECODE; out_valid rises on the
    // following edge and drops when the consumer takes the byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_data   <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            if (state_q == DECODE) de_data <= plain;
            if (deliver)                 out_valid <= 1'b0;
            else if (state_q == OUTPUT)  out_valid <= 1'b1;
        end
    end

    // Delivered-byte counter; wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          byte_cnt <= 8'h00;
        else if (deliver) byte_cnt <= byte_cnt + 8'd1;
    end

endmodule

// File: tb/tb_decrypt.sv
// Self-checking bench for decrypt: known-answer table, hand-built corner
// sequences, and random bytes checked against a behavioural model.
module tb_decrypt;
    import decrypt_pkg::*;

    localparam logic [7:0] KEY = 8'hA5;
    localparam logic [7:0] IV  = 8'h3C;
    localparam int         ROT = 3;

    // ---------------- clock / reset ----------------
    logic       tb_clk = 1'b0;
    logic       rst;
    logic [1:0] select;
    logic [7:0] en_data;
    logic       in_valid;
    logic       in_ready;
    logic       chain_clr;
    logic [7:0] de_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] byte_cnt;
    logic [1:0] state_dbg;

    always #5 tb_clk = ~tb_clk;

    decrypt #(.KEY(KEY), .IV(IV), .ROT(ROT)) dut (
        .clk       (tb_clk),
        .rst       (rst),
        .select    (select),
        .en_data   (en_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .chain_clr (chain_clr),
        .de_data   (de_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .byte_cnt  (byte_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] prev_m;
    logic [7:0] exp_cnt;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] c;
        logic       clr;
        logic [7:0] p;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode from the mode rules, using plain integer arithmetic.
    task automatic model_step(input logic [1:0] m, input logic [7:0] c,
                              input logic clr, output logic [7:0] p);
        int ci;
        ci = int'(c);
        if (clr) prev_m = IV;
        case (m)
            2'd0: p = c;
            2'd1: p = c ^ KEY;
            2'd2: p = 8'((ci / (1 << ROT)) + ((ci % (1 << ROT)) * (1 << (8 - ROT))));
            default: begin
                p = c ^ prev_m ^ KEY;
                prev_m = c;
            end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic run_byte(input logic [1:0] m, input logic [7:0] c, input logic clr,
                            input int hold, output logic [7:0] got);
        int waited;
        int edges;
        logic [7:0] exp_p;
        logic [7:0] cnt_before;
        waited = 0;
        edges = 0;
        while (!in_ready && waited < 20) begin
            @(posedge tb_clk); #1; waited++;
        end
        check("in_ready_wait", 8'(in_ready), 8'd1);
        select = m; en_data = c; chain_clr = clr; in_valid = 1'b1;
        @(posedge tb_clk);
        model_step(m, c, clr, exp_p);
        exp_q.push_back(exp_p);
        #1;
        in_valid = 1'b0; chain_clr = 1'b0;
        select = 2'($urandom); en_data = 8'($urandom);
        while (!out_valid && edges < 8) begin
            @(posedge tb_clk); #1; edges++;
        end
        check("latency", 8'(edges), 8'd2);
        got = de_data;
        cnt_before = byte_cnt;
        for (int h = 0; h < hold; h++) begin
            @(posedge tb_clk); #1;
            check("hold_data", de_data, got);
            check("hold_valid", 8'(out_valid), 8'd1);
            check("hold_in_ready", 8'(in_ready), 8'd0);
            check("hold_cnt", byte_cnt, cnt_before);
        end
        out_ready = 1'b1;
        @(posedge tb_clk); #1;
        out_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("byte_cnt", byte_cnt, exp_cnt);
        check("in_ready_after", 8'(in_ready), 8'd1);
        check("out_valid_after", 8'(out_valid), 8'd0);
        if (exp_q.size() > 0) check("de_data", got, exp_q.pop_front());
        else check("scoreboard_empty", 8'd1, 8'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- test ----------------
    initial begin
        logic [7:0] got;
        vecs[0] = '{2'b01, 8'h54, 1'b0, 8'hF1};
        vecs[1] = '{2'b10, 8'h75, 1'b0, 8'hAE};
        vecs[2] = '{2'b00, 8'hF0, 1'b0, 8'hF0};
        vecs[3] = '{2'b11, 8'h0F, 1'b1, 8'h96};
        vecs[4] = '{2'b01, 8'h00, 1'b0, 8'hA5};
        vecs[5] = '{2'b11, 8'hB6, 1'b0, 8'h1C};
        vecs[6] = '{2'b11, 8'hB6, 1'b1, 8'h2F};
        vecs[7] = '{2'b10, 8'h01, 1'b0, 8'h20};

        rst = 1'b1; in_valid = 1'b0; select = 2'b00; en_data = 8'h00;
        chain_clr = 1'b0; out_ready = 1'b0;
        prev_m = IV; exp_cnt = 8'h00;

        #12;
        check("rst_in_ready", 8'(in_ready), 8'd0);
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_de_data", de_data, 8'h00);
        check("rst_byte_cnt", byte_cnt, 8'h00);
        @(negedge tb_clk); rst = 1'b0; #1;
        check("release_in_ready", 8'(in_ready), 8'd1);

        // Known-answer table.
        for (int i = 0; i < 8; i++) begin
            run_byte(vecs[i].mode, vecs[i].c, vecs[i].clr, 0, got);
            check($sformatf("table_%0d", i), got, vecs[i].p);
        end

        // Standalone chain_clr while idle, then a chained byte uses IV.
        run_byte(2'b11, 8'h0F, 1'b0, 0, got);
        @(negedge tb_clk); chain_clr = 1'b1;
        @(posedge tb_clk); prev_m = IV; #1; chain_clr = 1'b0;
        run_byte(2'b11, 8'hB6, 1'b0, 0, got);
        check("clr_idle_chain", got, 8'h2F);

        // Consumer stalls for 5 cycles.
        run_byte(2'b01, 8'h54, 1'b0, 5, got);
        check("stall_value", got, 8'hF1);

        // Random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            run_byte(2'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
                     $urandom_range(0, 2), got);
        end

        // Reset while a byte sits in DECODE.
        select = 2'b01; en_data = 8'h54; in_valid = 1'b1;
        @(posedge tb_clk); #1;
        in_valid = 1'b0;
        rst = 1'b1; #1;
        check("mid_rst_out_valid", 8'(out_valid), 8'd0);
        check("mid_rst_de_data", de_data, 8'h00);
        check("mid_rst_byte_cnt", byte_cnt, 8'h00);
        check("mid_rst_in_ready", 8'(in_ready), 8'd0);
        prev_m = IV; exp_cnt = 8'h00;
        @(negedge tb_clk); rst = 1'b0; #1;
        check("mid_rst_release_ready", 8'(in_ready), 8'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge tb_clk); #1;
            check("mid_rst_no_output", 8'(out_valid), 8'd0);
        end

        // Chain restarts from IV after reset.
        run_byte(2'b11, 8'h0F, 1'b0, 0, got);
        check("post_rst_chain", got, 8'h96);

        // 255 more deliveries bring the counter back to zero.
        for (int i = 0; i < 255; i++) begin
            run_byte(2'($urandom), 8'($urandom), 1'b0, 0, got);
        end
        check("wrap_cnt", byte_cnt, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
